// File: rtl/hw_wrapper_pkg.sv
// Shared types, sizing constants and GF(2^8) helpers for the password vault.
package hw_wrapper_pkg;

    localparam int DEPTH    = 16;
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int BOOT_CYC = DEPTH;
    localparam int DW       = 128;

    typedef logic [DW-1:0] blk_t;

    typedef enum logic [2:0] {BOOT, IDLE, LOOKUP, STORE, ENC, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // S-box as multiplicative inverse (x^254) followed by the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

endpackage

// File: rtl/hw_wrapper_aes128_enc_core.sv
// Iterative AES-128 encryptor: key-add on start, then one round per clock with
// the round key expanded on the fly; ready pulses for one cycle with ct valid.
module aes128_enc_core
    import hw_wrapper_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  blk_t key,
    input  blk_t pt,
    output logic ready,
    output blk_t ct
);

    blk_t       st_q, st_d, rk_q, rk_d, rk_next;
    logic [3:0] round_q, round_d;
    logic [7:0] rcon_q, rcon_d;
    logic       busy_q, busy_d, ready_q, ready_d;

    // Byte n of the state sits at bits [127-8n -: 8]; column c holds bytes 4c..4c+3.
    function automatic blk_t sub_shift(input blk_t s);
        blk_t o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
        return o;
    endfunction

    function automatic blk_t mix_cols(input blk_t s);
        blk_t       o;
        logic [7:0] a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic blk_t expand(input blk_t k, input logic [7:0] rc);
        logic [31:0] rot, t, n0, n1, n2, n3;
        rot = {k[23:0], k[31:24]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {rc, 24'h0};
        n0  = k[127:96] ^ t;
        n1  = k[95:64] ^ n0;
        n2  = k[63:32] ^ n1;
        n3  = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    always_comb begin
        rk_next = expand(rk_q, rcon_q);
        st_d    = st_q;
        rk_d    = rk_q;
        rcon_d  = rcon_q;
        round_d = round_q;
        busy_d  = busy_q;
        ready_d = 1'b0;
        if (start) begin
            st_d    = pt ^ key;
            rk_d    = key;
            rcon_d  = 8'h01;
            round_d = 4'd1;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            // Final round skips MixColumns.
            st_d    = (round_q == 4'd10) ? (sub_shift(st_q) ^ rk_next)
                                         : (mix_cols(sub_shift(st_q)) ^ rk_next);
            rk_d    = rk_next;
            rcon_d  = xtime(rcon_q);
            round_d = round_q + 4'd1;
            if (round_q == 4'd10) begin
                busy_d  = 1'b0;
                ready_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= '0;
            rk_q    <= '0;
            rcon_q  <= 8'h01;
            round_q <= 4'd0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            st_q    <= st_d;
            rk_q    <= rk_d;
            rcon_q  <= rcon_d;
            round_q <= round_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
        end
    end

    assign ready = ready_q;
    assign ct    = st_q;

endmodule

// File: rtl/hw_wrapper.sv
// Password vault: 16-slot {account, password} table with a parallel account
// comparator; known accounts return AES-128(master_key, stored password).
module hw_wrapper
    import hw_wrapper_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic go,
    input  blk_t master_key,
    input  blk_t account,
    input  blk_t password,
    output logic done,
    output blk_t password_enc,
    output logic boot_done_signal
);

    state_t           state_q, state_d;
    blk_t             acct_q [DEPTH];
    blk_t             acct_d [DEPTH];
    blk_t             pw_q   [DEPTH];
    blk_t             pw_d   [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [IDX_W:0]   count_q, count_d;
    logic [IDX_W-1:0] boot_idx_q, boot_idx_d;
    blk_t             acct_lat_q, acct_lat_d, pw_lat_q, pw_lat_d, key_lat_q, key_lat_d;
    blk_t             sel_pw_q, sel_pw_d, enc_q, enc_d;
    logic             done_q, done_d, boot_done_q, boot_done_d, start_q, start_d;
    logic             hit;
    logic [IDX_W-1:0] hit_idx;
    logic             core_ready;
    blk_t             core_ct;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (acct_q[i] == acct_lat_q)) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        acct_d      = acct_q;
        pw_d        = pw_q;
        valid_d     = valid_q;
        count_d     = count_q;
        boot_idx_d  = boot_idx_q;
        acct_lat_d  = acct_lat_q;
        pw_lat_d    = pw_lat_q;
        key_lat_d   = key_lat_q;
        sel_pw_d    = sel_pw_q;
        enc_d       = enc_q;
        boot_done_d = boot_done_q;
        done_d      = 1'b0;
        start_d     = 1'b0;
        case (state_q)
            BOOT: begin
                acct_d[boot_idx_q]  = '0;
                pw_d[boot_idx_q]    = '0;
                valid_d[boot_idx_q] = 1'b0;
                boot_idx_d          = boot_idx_q + 1'b1;
                if (boot_idx_q == IDX_W'(BOOT_CYC - 1)) begin
                    boot_done_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            IDLE: begin
                if (go) begin
                    acct_lat_d = account;
                    pw_lat_d   = password;
                    key_lat_d  = master_key;
                    state_d    = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    sel_pw_d = pw_q[hit_idx];
                    start_d  = 1'b1;
                    state_d  = ENC;
                end else if (count_q < (IDX_W+1)'(DEPTH)) begin
                    state_d = STORE;
                end else begin
                    state_d = DONE;
                end
            end
            STORE: begin
                acct_d[count_q[IDX_W-1:0]]  = acct_lat_q;
                pw_d[count_q[IDX_W-1:0]]    = pw_lat_q;
                valid_d[count_q[IDX_W-1:0]] = 1'b1;
                count_d                     = count_q + 1'b1;
                state_d                     = DONE;
            end
            ENC: begin
                if (core_ready) begin
                    enc_d   = core_ct;
                    state_d = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            for (int i = 0; i < DEPTH; i++) begin
                acct_q[i] <= '0;
                pw_q[i]   <= '0;
            end
            valid_q     <= '0;
            count_q     <= '0;
            boot_idx_q  <= '0;
            acct_lat_q  <= '0;
            pw_lat_q    <= '0;
            key_lat_q   <= '0;
            sel_pw_q    <= '0;
            enc_q       <= '0;
            done_q      <= 1'b0;
            boot_done_q <= 1'b0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            acct_q      <= acct_d;
            pw_q        <= pw_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            boot_idx_q  <= boot_idx_d;
            acct_lat_q  <= acct_lat_d;
            pw_lat_q    <= pw_lat_d;
            key_lat_q   <= key_lat_d;
            sel_pw_q    <= sel_pw_d;
            enc_q       <= enc_d;
            done_q      <= done_d;
            boot_done_q <= boot_done_d;
            start_q     <= start_d;
        end
    end

    aes128_enc_core u_core (
        .clk   (clk),
        .rst   (rst),
        .start (start_q),
        .key   (key_lat_q),
        .pt    (sel_pw_q),
        .ready (core_ready),
        .ct    (core_ct)
    );

    assign done             = done_q;
    assign password_enc     = enc_q;
    assign boot_done_signal = boot_done_q;

endmodule

// File: tb/tb_hw_wrapper.sv
// Directed bench for hw_wrapper: boot, store, fetch against FIPS-197 vectors,
// full table, back-to-back requests and mid-encryption reset.
module tb_hw_wrapper;

    localparam logic [127:0] ACCT_A = 128'h5468617473206D79204B756E67204675;
    localparam logic [127:0] ACCT_B = 128'h52792047204B4686106D677374756E65;
    localparam logic [127:0] ACCT_C = 128'h6861567920475273747204B406D67E65;
    localparam logic [127:0] ACCT_X = 128'hFEEDFACE_0BADF00D_DEADBEEF_00000017;
    localparam logic [127:0] PT1    = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY1   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2    = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY2   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2    = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         rst;
    logic         go;
    logic [127:0] master_key, account, password, password_enc;
    logic         done, boot_done_signal;

    logic [127:0] exp_q[$];
    logic [127:0] last_enc;
    int           n_tests = 0;
    int           n_fail  = 0;
    int           edges;

    hw_wrapper dut (
        .clk              (clk),
        .rst              (rst),
        .go               (go),
        .master_key       (master_key),
        .account          (account),
        .password         (password),
        .done             (done),
        .password_enc     (password_enc),
        .boot_done_signal (boot_done_signal)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [127:0] fill_acct(input int i);
        return {96'hACC0_1111_2222_3333_4444_5555, 32'(i)};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Counts edges after rst falls until boot_done_signal rises.
    task automatic boot_wait(input bit hold_go);
        int rise;
        rise = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (hold_go && n >= 14) go = 1'b0;
            check("boot_done_low", 128'(done), 128'(0));
            check("boot_enc_zero", password_enc, 128'h0);
            if (boot_done_signal) begin
                rise = n;
                break;
            end
        end
        check("boot_latency", 128'(rise), 128'(16));
    endtask

    task automatic start_req(input logic [127:0] a, input logic [127:0] p, input logic [127:0] k);
        repeat ($urandom_range(0, 3)) @(posedge clk);
        @(negedge clk);
        account    = a;
        password   = p;
        master_key = k;
        go         = 1'b1;
    endtask

    task automatic wait_done(output int n_edges);
        n_edges = -1;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                n_edges = n;
                break;
            end
        end
    endtask

    task automatic pop_cmp(input string tag);
        logic [127:0] exp;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 128'(exp_q.size()), 128'(1));
        end else begin
            exp = exp_q.pop_front();
            check(tag, password_enc, exp);
        end
    endtask

    // One complete request with go dropped right after the sampling edge.
    task automatic do_req(input string tag, input logic [127:0] a, input logic [127:0] p,
                          input logic [127:0] k, input logic [127:0] exp_enc, input int lat);
        int n;
        exp_q.push_back(exp_enc);
        start_req(a, p, k);
        @(posedge clk);
        #1;
        go         = 1'b0;
        account    = rnd128();
        password   = rnd128();
        master_key = rnd128();
        wait_done(n);
        check({tag, "_latency"}, 128'(n), 128'(lat));
        pop_cmp({tag, "_enc"});
        @(posedge clk);
        #1;
        check({tag, "_done_width"}, 128'(done), 128'(0));
        check({tag, "_enc_held"}, password_enc, exp_enc);
        last_enc = exp_enc;
    endtask

    initial begin
        rst        = 1'b1;
        go         = 1'b1;
        account    = ACCT_A;
        password   = PT1;
        master_key = KEY1;
        last_enc   = '0;

        // Reset and boot, with go requested throughout reset and most of boot
        #12;
        check("rst_done", 128'(done), 128'(0));
        check("rst_enc", password_enc, 128'h0);
        check("rst_boot_done", 128'(boot_done_signal), 128'(0));
        #18;
        rst = 1'b0;
        boot_wait(1'b1);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("idle_no_req", 128'(done), 128'(0));
            check("boot_done_stays", 128'(boot_done_signal), 128'(1));
        end

        // Store, then FIPS-197 fetch with a different (ignored) password
        do_req("store_A", ACCT_A, PT1, rnd128(), last_enc, 3);
        do_req("fetch_A", ACCT_A, rnd128(), KEY1, CT1, 14);

        // Two accounts sharing a password
        do_req("store_B", ACCT_B, PT2, rnd128(), last_enc, 3);
        do_req("store_C", ACCT_C, PT2, rnd128(), last_enc, 3);
        do_req("fetch_B", ACCT_B, rnd128(), KEY2, CT2, 14);
        do_req("fetch_C", ACCT_C, rnd128(), KEY2, CT2, 14);
        do_req("refetch_A", ACCT_A, PT2, KEY1, CT1, 14);

        // Fill remaining 13 slots, then overflow
        for (int i = 0; i < 13; i++)
            do_req("store_fill", fill_acct(i), (i % 2 == 0) ? PT1 : PT2, rnd128(), last_enc, 3);
        do_req("store_full", ACCT_X, PT2, rnd128(), last_enc, 2);
        do_req("fetch_fill0", fill_acct(0), rnd128(), KEY1, CT1, 14);
        do_req("fetch_fill11", fill_acct(11), rnd128(), KEY2, CT2, 14);
        do_req("fetch_fill12", fill_acct(12), rnd128(), KEY1, CT1, 14);
        do_req("fetch_B_full", ACCT_B, rnd128(), KEY2, CT2, 14);
        do_req("fetch_A_full", ACCT_A, rnd128(), KEY1, CT1, 14);
        do_req("full_no_write", ACCT_X, PT1, KEY1, last_enc, 2);

        // Back-to-back: go held across done, inputs updated while done is high
        exp_q.push_back(CT2);
        start_req(fill_acct(1), rnd128(), KEY2);
        @(posedge clk);
        #1;
        wait_done(edges);
        check("b2b_first_latency", 128'(edges), 128'(14));
        @(negedge clk);
        account    = ACCT_A;
        password   = rnd128();
        master_key = KEY1;
        exp_q.push_back(CT1);
        pop_cmp("b2b_first_enc");
        @(posedge clk);
        #1;
        check("b2b_done_width", 128'(done), 128'(0));
        go         = 1'b0;
        account    = rnd128();
        master_key = rnd128();
        wait_done(edges);
        check("b2b_second_latency", 128'(edges), 128'(14));
        pop_cmp("b2b_second_enc");
        last_enc = CT1;

        // Reset in the middle of an encryption
        start_req(fill_acct(2), rnd128(), KEY1);
        @(posedge clk);
        #1;
        go = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_done", 128'(done), 128'(0));
        check("abort_enc", password_enc, 128'h0);
        check("abort_boot_done", 128'(boot_done_signal), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        boot_wait(1'b0);
        last_enc = '0;
        do_req("reboot_store_A", ACCT_A, PT1, KEY1, last_enc, 3);
        do_req("reboot_fetch_A", ACCT_A, rnd128(), KEY1, CT1, 14);
        do_req("reboot_store_B", ACCT_B, PT2, KEY2, last_enc, 3);

        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
